lsb_mem_ctrl: RTL and testbench

LSB_MEM_CTRL -- requirements
Module: lsb_mem_ctrl

---
 rtl/lsb_mem_ctrl_if.sv | 44 ++++
 rtl/lsb_mem_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_lsb_mem_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsb_mem_ctrl_if.sv
// Bus bundle between the memory controller and its environment.
// The "slave" side is the controller itself; the "master" side is
// everything around it: the load/store buffer, the instruction fetch
// unit, the byte-wide RAM and the UART buffer-full flag.
interface lsb_mem_ctrl_if;

  // Load/store buffer port
  logic        lsb_req;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic [5:0]  lsb_op;
  logic [31:0] lsb_rdata;
  logic        lsb_ok;

  // Instruction fetch port (always a 4-byte read)
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ok;

  // Byte-wide RAM port and UART back-pressure
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport slave (
    input  lsb_req, lsb_addr, lsb_wdata, lsb_op,
    input  if_req, if_addr,
    input  mem_din, io_buffer_full,
    output lsb_rdata, lsb_ok, if_rdata, if_ok,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output lsb_req, lsb_addr, lsb_wdata, lsb_op,
    output if_req, if_addr,
    output mem_din, io_buffer_full,
    input  lsb_rdata, lsb_ok, if_rdata, if_ok,
    input  mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/lsb_mem_ctrl.sv
// Byte-serial memory controller shared by the load/store buffer and the
// instruction fetch unit. One transaction at a time; each access is split
// into 1, 2 or 4 single-byte RAM cycles, little-endian.
module lsb_mem_ctrl (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  lsb_mem_ctrl_if.slave  bus
);

  // Opcode encoding shared with the load/store buffer
  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;

  // Latched transaction
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  n_q;        // byte count: 1, 2 or 4
  logic [2:0]  cnt_q;      // bytes addressed so far
  logic        is_lsb_q;   // 1 = LSB access, 0 = fetch
  logic [31:0] rbuf_q;     // read bytes assembled so far

  // Result registers, updated only when a read completes
  logic [31:0] lsb_rdata_q;
  logic [31:0] if_rdata_q;

  // A stall freezes the address, but the RAM keeps answering for the held
  // address. The byte that belonged to the previous address is saved on
  // the first frozen cycle and used on the first cycle after the stall.
  logic        frozen_q;
  logic [7:0]  din_hold_q;

  // Opcode decode
  logic        op_legal;
  logic        op_store;
  logic [2:0]  op_n;

  // Datapath helpers
  logic        accept_lsb;
  logic        accept_if;
  logic [7:0]  din_eff;
  logic [1:0]  cap_idx;
  logic [31:0] rd_word;
  logic [31:0] drive_addr;
  logic [7:0]  wr_byte;
  logic        wr_stall;
  logic        last_rd;
  logic        last_wr;

  // Raw FSM outputs before reset/enable gating
  logic [31:0] mem_a_raw;
  logic [7:0]  mem_dout_raw;
  logic        mem_wr_raw;
  logic        lsb_ok_raw;
  logic        if_ok_raw;

  // Decode the LSB opcode into byte count, direction and legality
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the case can infer a latch.
    op_legal = 1'b1;
    op_store = 1'b0;
    op_n     = 3'd4;
    case (bus.lsb_op)
      OP_LB, OP_LBU: op_n = 3'd1;
      OP_LH, OP_LHU: op_n = 3'd2;
      OP_LW:         op_n = 3'd4;
      OP_SB: begin
        op_n     = 3'd1;
        op_store = 1'b1;
      end
      OP_SH: begin
        op_n     = 3'd2;
        op_store = 1'b1;
      end
      OP_SW: begin
        op_n     = 3'd4;
        op_store = 1'b1;
      end
      default: op_legal = 1'b0;
    endcase
  end

  // LSB wins arbitration in IDLE; an illegal LSB op simply isn't seen
  assign accept_lsb = (state_q == ST_IDLE) && bus.lsb_req && op_legal;
  assign accept_if  = (state_q == ST_IDLE) && !accept_lsb && bus.if_req;

  // Byte addressing (wraps modulo 2^32 by construction)
  assign drive_addr = addr_q + {29'b0, cnt_q};
  assign wr_byte    = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
  assign wr_stall   = (addr_q[17:16] == 2'b11) && bus.io_buffer_full;
  assign last_rd    = (cnt_q == n_q);
  assign last_wr    = (cnt_q == n_q - 3'd1);

  // Merge the returning RAM byte into the assembled read word
  assign din_eff = frozen_q ? din_hold_q : bus.mem_din;
  assign cap_idx = cnt_q[1:0] - 2'd1;

  always_comb begin
    rd_word = rbuf_q;
    if (cnt_q != 3'd0) rd_word[{cap_idx, 3'b000} +: 8] = din_eff;
  end

  // Next-state and bus outputs
  always_comb begin
    state_d      = state_q;
    mem_a_raw    = 32'h0;
    mem_dout_raw = 8'h0;
    mem_wr_raw   = 1'b0;
    lsb_ok_raw   = 1'b0;
    if_ok_raw    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_lsb)     state_d = op_store ? ST_WRITE : ST_READ;
        else if (accept_if) state_d = ST_READ;
      end
      ST_READ: begin
        // n address cycles, then one more cycle to catch the last byte
        if (!last_rd) mem_a_raw = drive_addr;
        else          state_d   = ST_DONE;
      end
      ST_WRITE: begin
        mem_a_raw    = drive_addr;
        mem_dout_raw = wr_byte;
        if (!wr_stall) begin
          mem_wr_raw = 1'b1;
          if (last_wr) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        lsb_ok_raw = is_lsb_q;
        if_ok_raw  = !is_lsb_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset wins outright; a low rdy blocks writes and completion pulses
  assign bus.mem_a     = rst ? 32'h0 : mem_a_raw;
  assign bus.mem_dout  = rst ? 8'h0  : mem_dout_raw;
  assign bus.mem_wr    = mem_wr_raw & rdy & ~rst;
  assign bus.lsb_ok    = lsb_ok_raw & rdy & ~rst;
  assign bus.if_ok     = if_ok_raw  & rdy & ~rst;
  assign bus.lsb_rdata = lsb_rdata_q;
  assign bus.if_rdata  = if_rdata_q;

  // State register; holds while rdy is low
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (rst)      state_q <= ST_IDLE;
    else if (rdy) state_q <= state_d;
  end

  // Transaction latch, byte counter and read assembly
  always_ff @(posedge clk) begin
    // NOTE: the data registers are reset too, because the result outputs
    // and the stall bookkeeping must read as zero straight after reset.
    if (rst) begin
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      n_q         <= 3'd0;
      cnt_q       <= 3'd0;
      is_lsb_q    <= 1'b0;
      rbuf_q      <= 32'h0;
      lsb_rdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      frozen_q    <= 1'b0;
      din_hold_q  <= 8'h0;
    end else begin
      frozen_q <= !rdy;
      if (!rdy && !frozen_q) din_hold_q <= bus.mem_din;
      if (rdy) begin
        case (state_q)
          ST_IDLE: begin
            if (accept_lsb) begin
              addr_q   <= bus.lsb_addr;
              wdata_q  <= bus.lsb_wdata;
              n_q      <= op_n;
              is_lsb_q <= 1'b1;
              cnt_q    <= 3'd0;
              rbuf_q   <= 32'h0;
            end else if (accept_if) begin
              addr_q   <= bus.if_addr;
              wdata_q  <= 32'h0;
              n_q      <= 3'd4;
              is_lsb_q <= 1'b0;
              cnt_q    <= 3'd0;
              rbuf_q   <= 32'h0;
            end
          end
          ST_READ: begin
            rbuf_q <= rd_word;
            if (last_rd) begin
              cnt_q <= 3'd0;
              if (is_lsb_q) lsb_rdata_q <= rd_word;
              else          if_rdata_q  <= rd_word;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
          ST_WRITE: begin
            if (!wr_stall) cnt_q <= last_wr ? 3'd0 : cnt_q + 3'd1;
          end
          ST_DONE: cnt_q <= 3'd0;
          default: cnt_q <= 3'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsb_mem_ctrl.sv
// Directed bench for lsb_mem_ctrl: byte-wide RAM model, load/store/fetch
// sequences with hand-computed latencies and data, back-pressure, stall,
// arbitration and reset-abort cases.
module tb_lsb_mem_ctrl;

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  lsb_mem_ctrl_if bus ();

  lsb_mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // RAM: fixed preset contents plus whatever the DUT has written
  logic [7:0]  written [logic [31:0]];
  logic [31:0] wr_a [$];
  logic [7:0]  wr_d [$];

  function automatic logic [7:0] preset(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h11;
      32'h0000_0101: return 8'h22;
      32'h0000_0102: return 8'h33;
      32'h0000_0103: return 8'h44;
      32'h0000_0200: return 8'h5A;
      32'h0000_0201: return 8'h80;
      32'h0000_0202: return 8'hFF;
      32'h0000_0203: return 8'h13;
      32'h0000_0500: return 8'hEF;
      32'h0000_0501: return 8'hBE;
      32'h0000_0502: return 8'hAD;
      32'h0000_0503: return 8'hDE;
      32'hFFFF_FFFF: return 8'hAB;
      32'h0000_0000: return 8'hCD;
      default:       return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (written.exists(a)) return written[a];
    return preset(a);
  endfunction

  // RAM answers one cycle after the address; writes are logged
  always @(posedge clk) begin
    bus.mem_din <= ram_rd(bus.mem_a);
    if (bus.mem_wr) begin
      written[bus.mem_a] = bus.mem_dout;
      wr_a.push_back(bus.mem_a);
      wr_d.push_back(bus.mem_dout);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // The two completion pulses must never coincide
  always @(negedge clk) begin
    if (bus.lsb_ok || bus.if_ok)
      check("ok_excl", {31'b0, bus.lsb_ok & bus.if_ok}, 32'h0);
  end

  // Read (load or fetch): per-cycle address, ok latency, result word
  task automatic do_read(input string tag, input logic is_fetch, input logic [5:0] op,
                         input logic [31:0] addr, input int n, input logic [31:0] exp);
    int ok_cyc;
    logic ok_now;
    @(negedge clk);
    if (is_fetch) begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end else begin
      bus.lsb_req  = 1'b1;
      bus.lsb_op   = op;
      bus.lsb_addr = addr;
    end
    ok_cyc = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k <= n) check({tag, "_mem_a"}, bus.mem_a, addr + k - 1);
      ok_now = is_fetch ? bus.if_ok : bus.lsb_ok;
      if (ok_now) begin
        ok_cyc = k;
        bus.lsb_req = 1'b0;
        bus.if_req  = 1'b0;
        break;
      end
    end
    bus.lsb_req = 1'b0;
    bus.if_req  = 1'b0;
    check({tag, "_ok_cycle"}, ok_cyc, n + 2);
    check({tag, "_rdata"}, is_fetch ? bus.if_rdata : bus.lsb_rdata, exp);
  endtask

  // Store: optional UART back-pressure for full_cyc cycles, ok latency,
  // exact sequence of RAM writes
  task automatic do_write(input string tag, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int n, input int full_cyc);
    int ok_cyc;
    logic [31:0] wd;
    @(negedge clk);
    wr_a.delete();
    wr_d.delete();
    bus.io_buffer_full = (full_cyc > 0);
    bus.lsb_req   = 1'b1;
    bus.lsb_op    = op;
    bus.lsb_addr  = addr;
    bus.lsb_wdata = wdata;
    ok_cyc = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k <= full_cyc) check({tag, "_stall_wr"}, {31'b0, bus.mem_wr}, 32'h0);
      if (k == full_cyc + 1) bus.io_buffer_full = 1'b0;
      if (bus.lsb_ok) begin
        ok_cyc = k;
        bus.lsb_req = 1'b0;
        break;
      end
    end
    bus.lsb_req = 1'b0;
    bus.io_buffer_full = 1'b0;
    check({tag, "_ok_cycle"}, ok_cyc, n + 1 + full_cyc);
    check({tag, "_wr_count"}, wr_a.size(), n);
    wd = wdata;
    for (int j = 0; j < n && j < wr_a.size(); j++) begin
      check({tag, "_wr_addr"}, wr_a[j], addr + j);
      check({tag, "_wr_data"}, {24'b0, wr_d[j]}, {24'b0, wd[8*j +: 8]});
    end
  endtask

  initial begin
    int lok, iok, okc, busy;
    rst = 1'b1;
    rdy = 1'b1;
    bus.lsb_req = 1'b0;
    bus.lsb_addr = 32'h0;
    bus.lsb_wdata = 32'h0;
    bus.lsb_op = 6'h0;
    bus.if_req = 1'b0;
    bus.if_addr = 32'h0;
    bus.io_buffer_full = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_a", bus.mem_a, 32'h0);
    check("rst_mem_wr", {31'b0, bus.mem_wr}, 32'h0);
    check("rst_mem_dout", {24'b0, bus.mem_dout}, 32'h0);
    check("rst_lsb_ok", {31'b0, bus.lsb_ok}, 32'h0);
    check("rst_if_ok", {31'b0, bus.if_ok}, 32'h0);
    check("rst_lsb_rdata", bus.lsb_rdata, 32'h0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    rst = 1'b0;

    // Loads of every width, address wrap, and a fetch
    do_read("lw",       1'b0, OP_LW,  32'h0000_0100, 4, 32'h4433_2211);
    do_read("lh",       1'b0, OP_LH,  32'h0000_0201, 2, 32'h0000_FF80);
    repeat (3) @(negedge clk);
    check("rdata_hold", bus.lsb_rdata, 32'h0000_FF80);
    do_read("lbu",      1'b0, OP_LBU, 32'h0000_0102, 1, 32'h0000_0033);
    do_read("lb",       1'b0, OP_LB,  32'h0000_0201, 1, 32'h0000_0080);
    do_read("lhu_wrap", 1'b0, OP_LHU, 32'hFFFF_FFFF, 2, 32'h0000_CDAB);
    do_read("fetch",    1'b1, 6'h0,   32'h0000_0500, 4, 32'hDEAD_BEEF);

    // Stores: UART stall, plain half-word, IO word without stall, readback
    do_write("sb_io", OP_SB, 32'h0003_0000, 32'h1234_5678, 1, 3);
    do_write("sh",    OP_SH, 32'h0000_0600, 32'hAABB_CCDD, 2, 0);
    do_write("sw_io", OP_SW, 32'h0003_0010, 32'h0A0B_0C0D, 4, 0);
    do_read("readback", 1'b0, OP_LW, 32'h0000_0600, 4, 32'h0000_CCDD);

    // Illegal opcode: no ok, no RAM activity
    @(negedge clk);
    bus.lsb_req  = 1'b1;
    bus.lsb_op   = 6'h3F;
    bus.lsb_addr = 32'h0000_0100;
    okc = 0;
    busy = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.lsb_ok || bus.if_ok) okc++;
      if (bus.mem_a != 32'h0 || bus.mem_wr) busy++;
    end
    bus.lsb_req = 1'b0;
    check("illegal_ok", okc, 0);
    check("illegal_mem", busy, 0);

    // rdy low for 5 cycles during a fetch
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0100;
    iok = -1;
    busy = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k >= 3 && k <= 7) begin
        if (bus.mem_a !== 32'h0000_0101 || bus.mem_wr !== 1'b0 || bus.if_ok !== 1'b0) busy++;
      end
      if (k == 2) rdy = 1'b0;
      if (k == 7) rdy = 1'b1;
      if (bus.if_ok) begin
        iok = k;
        bus.if_req = 1'b0;
        break;
      end
    end
    bus.if_req = 1'b0;
    rdy = 1'b1;
    check("freeze_hold", busy, 0);
    check("freeze_ok_cycle", iok, 11);
    check("freeze_rdata", bus.if_rdata, 32'h4433_2211);

    // LSB and fetch requested together: LSB first, fetch right after
    @(negedge clk);
    bus.lsb_req  = 1'b1;
    bus.lsb_op   = OP_LW;
    bus.lsb_addr = 32'h0000_0100;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0200;
    lok = -1;
    iok = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) check("both_first_a", bus.mem_a, 32'h0000_0100);
      if (k == 8) check("both_fetch_a", bus.mem_a, 32'h0000_0200);
      if (bus.lsb_ok && lok < 0) begin
        lok = k;
        bus.lsb_req = 1'b0;
      end
      if (bus.if_ok && iok < 0) begin
        iok = k;
        bus.if_req = 1'b0;
      end
      if (lok >= 0 && iok >= 0) break;
    end
    bus.lsb_req = 1'b0;
    bus.if_req  = 1'b0;
    check("both_lsb_ok_cycle", lok, 6);
    check("both_if_ok_cycle", iok, 13);
    check("both_lsb_rdata", bus.lsb_rdata, 32'h4433_2211);
    check("both_if_rdata", bus.if_rdata, 32'h13FF_805A);

    // Reset in the middle of a word store
    @(negedge clk);
    wr_a.delete();
    wr_d.delete();
    bus.lsb_req   = 1'b1;
    bus.lsb_op    = OP_SW;
    bus.lsb_addr  = 32'h0000_0400;
    bus.lsb_wdata = 32'h1122_3344;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.lsb_req = 1'b0;
    @(negedge clk);
    check("abort_mem_wr", {31'b0, bus.mem_wr}, 32'h0);
    check("abort_mem_a", bus.mem_a, 32'h0);
    check("abort_mem_dout", {24'b0, bus.mem_dout}, 32'h0);
    rst = 1'b0;
    okc = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.lsb_ok || bus.if_ok) okc++;
    end
    check("abort_ok", okc, 0);
    check("abort_wr_count", wr_a.size(), 2);
    if (wr_a.size() >= 2) begin
      check("abort_wr0_addr", wr_a[0], 32'h0000_0400);
      check("abort_wr0_data", {24'b0, wr_d[0]}, 32'h0000_0044);
      check("abort_wr1_addr", wr_a[1], 32'h0000_0401);
      check("abort_wr1_data", {24'b0, wr_d[1]}, 32'h0000_0033);
    end
    check("abort_lsb_rdata", bus.lsb_rdata, 32'h0);
    check("abort_if_rdata", bus.if_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
